if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of pc_gen and decode. Owns the architectural PC register: it presents pc_o to
//  pc_gen and registers pc_gen's pc_next on every accepted fetch. Issues in-order requests to instruction memory with a
//  req/gnt handshake and buffers returned words with their PC in a small FIFO. Hands {pc, instruction} to decode with

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit_fifo.sv | 64 ++++++
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch FSM encoding (boot, run, drain after redirect)
//   FETCH_RESET_PC : default PC loaded on reset
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_S_BOOT  = 2'd0,
        FETCH_S_RUN   = 2'd1,
        FETCH_S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with registered head (no bypass).
//   clock, rst_n : clock, asynchronous active-low reset (contents cleared)
//   clear        : synchronous flush of pointers/count, priority over push/pop
//   push, wdata  : write request and data
//   pop          : read request (ignored when empty)
//   rdata        : head entry
//   full, empty  : occupancy flags
//   count        : number of valid entries ($clog2(DEPTH)+1 bits)
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // Push while full is allowed only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage between pc_gen and decode.
//   clock, rst_n          : clock, asynchronous active-low reset
//   pc_o, pause_o         : current fetch PC and stall to pc_gen
//   pc_next               : next PC from pc_gen, registered on each accepted fetch
//   flush, flush_pc       : late redirect, highest priority
//   imem_req/addr/gnt     : in-order request handshake to instruction memory
//   imem_rvalid/rdata     : in-order responses
//   id_valid/ins/pc/ready : {pc, instruction} handoff to decode
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    output logic        pause_o,
    input  logic [31:0] pc_next,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q;
    logic [CW-1:0] discard_q, discard_d;

    logic          accept;
    logic          resp;
    logic          id_pop;
    logic [CW-1:0] in_flight;
    logic [CW:0]   credits_used;

    logic [31:0]   tag_rdata;
    logic          tag_full, tag_empty, tag_pop;
    logic [CW-1:0] tag_count;
    logic [63:0]   inst_rdata;
    logic          inst_full, inst_empty, inst_push;
    logic [CW-1:0] inst_count;

    // The tag queue holds exactly one entry per outstanding request, so its
    // count doubles as the outstanding-request counter.
    assign in_flight = (state_q == FETCH_S_DRAIN) ? discard_q : tag_count;
    assign resp      = imem_rvalid && (in_flight != '0);
    assign id_pop    = id_valid && id_ready;

    // An entry leaving to decode this cycle frees its credit immediately,
    // which is what sustains one fetch per cycle at DEPTH=2.
    assign credits_used = (CW+1)'(tag_count) + (CW+1)'(inst_count) - (CW+1)'(id_pop);

    assign imem_req  = (state_q == FETCH_S_RUN) && !flush && (credits_used < (CW+1)'(DEPTH));
    assign accept    = imem_req && imem_gnt;
    assign tag_pop   = resp && (state_q == FETCH_S_RUN);
    assign inst_push = tag_pop;

    assign pause_o   = !accept;
    assign pc_o      = pc_q;
    assign imem_addr = pc_q;
    assign id_valid  = !inst_empty;
    assign id_pc     = inst_rdata[63:32];
    assign id_ins    = inst_rdata[31:0];

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clock (clock),
        .rst_n (rst_n),
        .clear (flush),
        .push  (accept),
        .wdata (pc_q),
        .pop   (tag_pop),
        .rdata (tag_rdata),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_inst_q (
        .clock (clock),
        .rst_n (rst_n),
        .clear (flush),
        .push  (inst_push),
        .wdata ({tag_rdata, imem_rdata}),
        .pop   (id_pop),
        .rdata (inst_rdata),
        .full  (inst_full),
        .empty (inst_empty),
        .count (inst_count)
    );

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (flush) begin
            // Everything still in flight after this cycle's response is stale.
            discard_d = in_flight - CW'(resp);
            state_d   = (discard_d != '0) ? FETCH_S_DRAIN : FETCH_S_RUN;
        end else begin
            case (state_q)
                FETCH_S_BOOT:  state_d = FETCH_S_RUN;
                FETCH_S_RUN:   state_d = FETCH_S_RUN;
                FETCH_S_DRAIN: begin
                    if (resp) begin
                        discard_d = discard_q - CW'(1);
                        if (discard_q == CW'(1)) begin
                            state_d = FETCH_S_RUN;
                        end
                    end
                end
                default:       state_d = FETCH_S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_S_BOOT;
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (flush) begin
                pc_q <= flush_pc;
            end else if (accept) begin
                pc_q <= pc_next;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (rst_n) begin
            assert (!(imem_rvalid && (in_flight == '0)))
                else $error("if_fetch_unit: imem_rvalid with no request in flight");
            assert (!(accept && tag_full))
                else $error("if_fetch_unit: request accepted with tag queue full");
            assert (!(inst_push && inst_full && !id_pop))
                else $error("if_fetch_unit: instruction FIFO overflow");
            assert (!(tag_pop && tag_empty))
                else $error("if_fetch_unit: tag queue underflow");
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: an instruction-memory model answers
// grants in order, a PC model predicts every fetch address, and a monitor
// compares each decode handoff against the scoreboard queue.
module tb_if_fetch_unit;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o;
    logic        pause_o;
    logic [31:0] pc_next;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_ready;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];   // expected id_pc sequence
    logic [31:0] rq[$];   // addresses granted, awaiting a response
    logic [31:0] mpc;     // model of the next fetch address
    logic        hold;    // memory withholds responses while set

    if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .pc_o        (pc_o),
        .pause_o     (pause_o),
        .pc_next     (pc_next),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ins      (id_ins),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    always #10 clock = ~clock;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: entered at a falling edge with inputs set. Samples the
    // handshake, crosses the rising edge, then presents the next response.
    task automatic tick();
        logic [31:0] a;
        #1;
        if (imem_req && imem_gnt) begin
            chk("fetch_addr", imem_addr, mpc);
            rq.push_back(imem_addr);
            sb.push_back(mpc);
            mpc = mpc + 32'd4;
        end
        @(posedge clock);
        @(negedge clock);
        pc_next = pc_o + 32'd4;
        if (!hold && rq.size() > 0) begin
            a           = rq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = ins_of(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_o"},     pc_o,     32'h0);
        chk({tag, "_req"},      {31'b0, imem_req}, 32'h0);
        chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, "_pause"},    {31'b0, pause_o},  32'h1);
        chk({tag, "_id_pc"},    id_pc,    32'h0);
        chk({tag, "_id_ins"},   id_ins,   32'h0);
    endtask

    // Scoreboard monitor: every decode handshake must match the oldest expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            #3;
            if (rst_n === 1'b1 && id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_id: got id_pc %h with no expected entry", id_pc);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_ins", id_ins, ins_of(e));
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        pc_next     = 32'h4;
        flush       = 1'b0;
        flush_pc    = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_ready    = 1'b0;
        hold        = 1'b0;
        mpc         = 32'h0;

        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming with single-cycle memory latency.
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        #1 chk("boot_no_req", {31'b0, imem_req}, 32'h0);
        tick();
        tick();
        tick();
        chk("first_id_valid", {31'b0, id_valid}, 32'h1);
        chk("first_id_pc", id_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("steady_pause", {31'b0, pause_o}, 32'h0);
            chk("steady_valid", {31'b0, id_valid}, 32'h1);
            tick();
        end

        // Decode stalls: FIFO fills, credits run out, PC holds.
        id_ready = 1'b0;
        repeat (4) tick();
        #1;
        chk("stall_req", {31'b0, imem_req}, 32'h0);
        chk("stall_pause", {31'b0, pause_o}, 32'h1);
        chk("stall_valid", {31'b0, id_valid}, 32'h1);
        chk("stall_pc", pc_o, mpc);
        tick();
        chk("stall_pc_held", pc_o, mpc);
        id_ready = 1'b1;
        repeat (3) tick();

        // Memory withholds grants.
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nognt_pause", {31'b0, pause_o}, 32'h1);
            chk("nognt_pc", pc_o, mpc);
            chk("nognt_addr", imem_addr, mpc);
            tick();
        end
        repeat (3) tick();

        // Flush with two requests outstanding and their responses late.
        hold     = 1'b1;
        imem_gnt = 1'b1;
        repeat (3) tick();
        #1 chk("credits_full_req", {31'b0, imem_req}, 32'h0);
        flush    = 1'b1;
        flush_pc = 32'h80;
        tick();
        flush = 1'b0;
        sb.delete();
        mpc = 32'h80;
        chk("flush1_pc", pc_o, 32'h80);
        chk("flush1_valid", {31'b0, id_valid}, 32'h0);
        #1 chk("drain_no_req", {31'b0, imem_req}, 32'h0);
        hold = 1'b0;
        repeat (8) tick();

        // Flush coinciding with a response and a would-be grant.
        flush    = 1'b1;
        flush_pc = 32'h200;
        #1;
        chk("flush2_rvalid_present", {31'b0, imem_rvalid}, 32'h1);
        chk("flush2_blocks_req", {31'b0, imem_req}, 32'h0);
        tick();
        flush = 1'b0;
        sb.delete();
        mpc = 32'h200;
        chk("flush2_pc", pc_o, 32'h200);
        chk("flush2_valid", {31'b0, id_valid}, 32'h0);
        #1 chk("flush2_no_drain", {31'b0, imem_req}, 32'h1);
        repeat (6) tick();

        // Asynchronous reset between clock edges.
        #5;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        rq.delete();
        sb.delete();
        mpc     = 32'h0;
        pc_next = 32'h4;
        #1 chk_reset_outputs("async_reset");
        @(negedge clock);
        rst_n = 1'b1;
        repeat (8) tick();

        // Drain everything and confirm nothing was lost.
        imem_gnt = 1'b0;
        repeat (6) tick();
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
